// File: rtl/lsq_pkg.sv
// Shared types for the lsq_ring load-store queue: operation/size encodings,
// per-entry control flags and the ring-pointer width helper.
package lsq_pkg;

   typedef enum logic {
      LOAD  = 1'b0,
      STORE = 1'b1
   } op_e;

   typedef enum logic {
      WORD = 1'b0,
      BYTE = 1'b1
   } size_e;

   // Wide fields (pc, addr, data) live in separate arrays so this stays width-independent.
   typedef struct packed {
      logic  valid;
      op_e   op;
      size_e size;
      logic  addr_vld;
      logic  issued;
   } lsq_entry_t;

   function automatic int lsq_ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/lsq_fwd_match.sv
// Age-masked store search for one load slot: finds the youngest older store with
// the same address and flags older stores whose address is still unknown.
module lsq_fwd_match
   import lsq_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int ADDR_W = 32,
   localparam int PTR_W  = lsq_ptr_w(DEPTH)
) (
   input  logic [PTR_W-1:0]             head,
   input  logic [PTR_W-1:0]             ld_idx,
   input  lsq_entry_t [DEPTH-1:0]       ent,
   input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
   output logic                         hit,
   output logic [PTR_W-1:0]             hit_idx,
   output logic                         size_mismatch,
   output logic                         older_store_unresolved
);

   logic [PTR_W-1:0] rel_ld;
   logic [PTR_W-1:0] scan_idx;

   assign rel_ld = ld_idx - head;

   // Walking oldest to youngest, a later match overwrites an earlier one.
   always_comb begin
      hit                    = 1'b0;
      hit_idx                = '0;
      older_store_unresolved = 1'b0;
      scan_idx               = head;
      for (int o = 0; o < DEPTH; o++) begin
         scan_idx = head + PTR_W'(o);
         if ((PTR_W'(o) < rel_ld) && ent[scan_idx].valid && (ent[scan_idx].op == STORE)) begin
            if (!ent[scan_idx].addr_vld) begin
               older_store_unresolved = 1'b1;
            end else if (addr[scan_idx] == addr[ld_idx]) begin
               hit     = 1'b1;
               hit_idx = scan_idx;
            end
         end
      end
   end

   assign size_mismatch = hit && (ent[hit_idx].size != ent[ld_idx].size);

endmodule

// File: rtl/lsq_ring.sv
// Age-ordered circular load-store queue with disambiguation, store-to-load
// forwarding, registered issue and dual in-order retire. Define LSQ_FLUSH_EN for a flush input.
module lsq_ring
   import lsq_pkg::*;
#(
   parameter  int DEPTH  = 16,
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   localparam int PTR_W  = lsq_ptr_w(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rstn,
`ifdef LSQ_FLUSH_EN
   input  logic              flush,
`endif
   input  logic              dis_valid,
   output logic              dis_ready,
   input  logic              dis_is_store,
   input  logic              dis_size,
   input  logic [ADDR_W-1:0] dis_pc,
   input  logic [DATA_W-1:0] dis_data,
   input  logic              agu_valid,
   input  logic [ADDR_W-1:0] agu_pc,
   input  logic [ADDR_W-1:0] agu_addr,
   input  logic              ret1_valid,
   input  logic              ret2_valid,
   input  logic [ADDR_W-1:0] ret1_pc,
   input  logic [ADDR_W-1:0] ret2_pc,
   output logic              iss_valid,
   input  logic              iss_ready,
   output logic [ADDR_W-1:0] iss_pc,
   output logic [ADDR_W-1:0] iss_addr,
   output logic              iss_is_store,
   output logic              iss_size,
   output logic [DATA_W-1:0] iss_data,
   output logic              iss_fwd,
   output logic [CNT_W-1:0]  count
);

   lsq_entry_t [DEPTH-1:0]       ent_reg, ent_next;
   logic [DEPTH-1:0][ADDR_W-1:0] pc_reg, addr_reg;
   logic [DEPTH-1:0][DATA_W-1:0] data_reg;
   logic [PTR_W-1:0]             head_reg, head_next, tail_reg, tail_next, head_plus1;
   logic [CNT_W-1:0]             count_reg, count_next;

   logic [DEPTH-1:0]             agu_hit, elig, fwd_hit, fwd_mism, fwd_unres;
   logic [DEPTH-1:0][PTR_W-1:0]  fwd_idx;

   logic              do_flush, dis_fire, ret1_fire, ret2_fire, iss_load;
   logic [1:0]        nret;
   logic              sel_found, sel_fwd;
   logic [PTR_W-1:0]  sel_idx, fwd_src;
   logic [DATA_W-1:0] sel_data;

   logic              iss_valid_reg, iss_is_store_reg, iss_size_reg, iss_fwd_reg;
   logic [ADDR_W-1:0] iss_pc_reg, iss_addr_reg;
   logic [DATA_W-1:0] iss_data_reg;

`ifdef LSQ_FLUSH_EN
   assign do_flush = flush;
`else
   assign do_flush = 1'b0;
`endif

   assign dis_ready  = (count_reg != CNT_W'(DEPTH));
   assign dis_fire   = dis_valid && dis_ready;
   assign head_plus1 = head_reg + PTR_W'(1);

   assign ret1_fire = ret1_valid && ent_reg[head_reg].valid && ent_reg[head_reg].issued
                      && (pc_reg[head_reg] == ret1_pc);
   assign ret2_fire = ret1_fire && ret2_valid && ent_reg[head_plus1].valid
                      && ent_reg[head_plus1].issued && (pc_reg[head_plus1] == ret2_pc);
   assign nret      = {1'b0, ret1_fire} + {1'b0, ret2_fire};

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      lsq_fwd_match #(
         .DEPTH  (DEPTH),
         .ADDR_W (ADDR_W)
      ) u_fwd (
         .head                   (head_reg),
         .ld_idx                 (PTR_W'(gi)),
         .ent                    (ent_reg),
         .addr                   (addr_reg),
         .hit                    (fwd_hit[gi]),
         .hit_idx                (fwd_idx[gi]),
         .size_mismatch          (fwd_mism[gi]),
         .older_store_unresolved (fwd_unres[gi])
      );

      // Slot being dispatched is still invalid here, so a same-cycle broadcast misses it.
      assign agu_hit[gi] = agu_valid && ent_reg[gi].valid && !ent_reg[gi].addr_vld
                           && (pc_reg[gi] == agu_pc);

      assign elig[gi] = ent_reg[gi].valid && !ent_reg[gi].issued && ent_reg[gi].addr_vld
                        && ((ent_reg[gi].op == STORE) || (!fwd_unres[gi] && !fwd_mism[gi]));
   end

   // Scan youngest to oldest so the oldest eligible entry wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int o = DEPTH - 1; o >= 0; o--) begin
         if (elig[head_reg + PTR_W'(o)]) begin
            sel_found = 1'b1;
            sel_idx   = head_reg + PTR_W'(o);
         end
      end
   end

   always_comb begin
      sel_data = '0;
      sel_fwd  = 1'b0;
      fwd_src  = fwd_idx[sel_idx];
      if (ent_reg[sel_idx].op == STORE) begin
         sel_data = data_reg[sel_idx];
      end else if (fwd_hit[sel_idx]) begin
         sel_fwd  = 1'b1;
         sel_data = (ent_reg[fwd_src].size == BYTE) ? {{(DATA_W-8){1'b0}}, data_reg[fwd_src][7:0]}
                                                    : data_reg[fwd_src];
      end
   end

   assign iss_load = !do_flush && sel_found && (!iss_valid_reg || iss_ready);

   always_comb begin
      ent_next = ent_reg;
      for (int i = 0; i < DEPTH; i++) begin
         if (agu_hit[i]) ent_next[i].addr_vld = 1'b1;
         if (iss_load && (sel_idx == PTR_W'(i))) ent_next[i].issued = 1'b1;
      end
      if (ret1_fire) ent_next[head_reg].valid   = 1'b0;
      if (ret2_fire) ent_next[head_plus1].valid = 1'b0;
      if (dis_fire) begin
         ent_next[tail_reg] = '{valid: 1'b1, op: op_e'(dis_is_store), size: size_e'(dis_size),
                                addr_vld: 1'b0, issued: 1'b0};
      end
      if (do_flush) begin
         for (int i = 0; i < DEPTH; i++) ent_next[i].valid = 1'b0;
      end
   end

   always_comb begin
      head_next  = head_reg + PTR_W'(nret);
      tail_next  = tail_reg + PTR_W'(dis_fire);
      count_next = count_reg + CNT_W'(dis_fire) - CNT_W'(nret);
      if (do_flush) begin
         head_next  = tail_reg;
         tail_next  = tail_reg;
         count_next = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ent_reg   <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         ent_reg   <= ent_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   // Payload storage needs no reset; validity is tracked in ent_reg.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (agu_hit[i]) addr_reg[i] <= agu_addr;
      end
      if (dis_fire) begin
         pc_reg[tail_reg]   <= dis_pc;
         data_reg[tail_reg] <= dis_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         iss_valid_reg    <= 1'b0;
         iss_pc_reg       <= '0;
         iss_addr_reg     <= '0;
         iss_is_store_reg <= 1'b0;
         iss_size_reg     <= 1'b0;
         iss_data_reg     <= '0;
         iss_fwd_reg      <= 1'b0;
      end else if (do_flush) begin
         iss_valid_reg <= 1'b0;
      end else if (!iss_valid_reg || iss_ready) begin
         iss_valid_reg <= sel_found;
         if (sel_found) begin
            iss_pc_reg       <= pc_reg[sel_idx];
            iss_addr_reg     <= addr_reg[sel_idx];
            iss_is_store_reg <= (ent_reg[sel_idx].op == STORE);
            iss_size_reg     <= (ent_reg[sel_idx].size == BYTE);
            iss_data_reg     <= sel_data;
            iss_fwd_reg      <= sel_fwd;
         end
      end
   end

   assign iss_valid    = iss_valid_reg;
   assign iss_pc       = iss_pc_reg;
   assign iss_addr     = iss_addr_reg;
   assign iss_is_store = iss_is_store_reg;
   assign iss_size     = iss_size_reg;
   assign iss_data     = iss_data_reg;
   assign iss_fwd      = iss_fwd_reg;
   assign count        = count_reg;

endmodule
